fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Instruction-fetch controller that owns and sequences the core's program counter. Each cycle it selects the next PC (sequential +4, branch redirect or reset vector). It runs a single-outstanding request/acknowledge transaction with instruction memory and presents fetched instructions to decode through a stallable one-entry output register. It sits between the instruction memory port and the decode stage, replacing the free-running PC register load.

## Interface
Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded by reset; bits [1:0] must be 0.

Ports:
- clock  in  1  sole clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- branch_valid  in  1  redirect request from execute, single-cycle pulse
- branch_target  in  32  redirect address; bits [1:0] ignored (forced to 0)
- stall  in  1  decode cannot accept the instruction currently presented
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  32  fetch address, word aligned
- imem_ack  in  1  memory completes the request this cycle; imem_rdata is valid
- imem_rdata  in  32  instruction word
- instr_valid  out  1  instr / instr_pc hold a valid instruction
- instr  out  32  fetched instruction
- instr_pc  out  32  address instr was fetched from
- pc  out  32  next address to be fetched

## Operation
- States: IDLE, ISSUE, REQ.
- Reset values: state=IDLE, pc=RESET_VECTOR, instr_valid=0, instr=0, instr_pc=0, discard=0, imem_req=0.
- IDLE always goes to ISSUE; it exists only for the first cycle after reset.
- slot_free = !instr_valid || !stall. Consumption happens when instr_valid && !stall.
- imem_req = (state==REQ) || (state==ISSUE && slot_free && !branch_valid). This is a Mealy output.
- imem_addr = req_addr in REQ, else pc. req_addr latches pc in the issuing cycle.
- Once raised, imem_req stays high with a stable imem_addr until the cycle it meets imem_ack. At most one transaction is outstanding.
- Completion is imem_req && imem_ack.
  - On completion with discard=0 and no branch_valid: instr<=imem_rdata, instr_pc<=imem_addr, instr_valid<=1, pc<=pc+4.
  - State then goes to ISSUE.
  - A request issued without ack moves the state to REQ.
- Instruction not consumed and no completion: instr_valid holds its value.
- branch_valid has highest priority after reset:
  - pc <= {branch_target[31:2],2'b00}; instr_valid<=0.
  - If a transaction is outstanding and does not complete this cycle, set discard=1.
  - A completion in the branch cycle, or a completion while discard=1, drops its data and clears discard. pc is not incremented.
- pc+4 wraps modulo 2^32. 32'hFFFF_FFFC is followed by 32'h0000_0000.

## Timing
- First imem_req rises in the second cycle after reset deasserts (IDLE, then ISSUE).
- Zero-wait memory (ack in the issue cycle) with stall=0 gives one instruction per cycle. instr_valid is asserted in the cycle after completion.
- N-cycle ack latency gives one instruction per N+1 cycles (ISSUE, then N cycles in REQ).
- Stall held: at most one further fetch completes into the emptied slot; afterwards imem_req stays low.
- Branch-to-first-fetch latency:
  - No transaction in flight: the redirected request issues in the next cycle.
  - Transaction in flight: it issues in the cycle after the outstanding ack.
- Reset mid-transaction abandons the request; imem_req=0 from the next cycle. Instruction memory must accept a dropped request under reset.
- Simultaneous branch_valid and stall: the branch wins and the slot is flushed.

## Structure
- Shared package fetch_pkg:
  - fetch_state_t enum {IDLE, ISSUE, REQ}
  - ADDR_W=32
  - INSTR_STEP=32'd4
  - default RESET_VECTOR
- One natural sub-module: pc_register, a 32-bit register with synchronous reset-to-vector and load enable. It is instantiated for pc and reused later for other architectural registers.
- The FSM, discard flag, req_addr and output register stay in fetch_sequencer.

## Test plan
- Reset, zero-wait memory returning imem_rdata=addr^32'hE000_0000, stall=0:
  - imem_addr runs 0x0, 0x4, 0x8, …, one per cycle.
  - instr_pc matches the fetched address.
  - First instr_valid appears in cycle 3 after reset.
- ack latency 2 with stall=0: one instruction every 3 cycles; imem_addr stays stable while imem_req=1 and ack=0.
- stall held 5 cycles after instr_pc=0x8:
  - instr and instr_pc hold.
  - Exactly one more completion, for 0xC, occurs.
  - On release, 0xC is presented next and there are no duplicates or gaps.
- branch_valid, target 0x0000_1002, while a 3-cycle fetch of 0x10 is outstanding:
  - instr_valid drops next cycle.
  - The 0x10 data is discarded.
  - The next request address is 0x1000.
- RESET_VECTOR=32'hFFFF_FFF8: fetch addresses are 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0, 0x4.
- Assert reset while imem_req=1 and ack=0:
  - Next cycle: imem_req=0, instr_valid=0, pc=RESET_VECTOR.
  - The fetch sequence restarts normally.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg
//   Shared definitions for the instruction-fetch slice: FSM state encoding,
//   address width, sequential PC step and the default reset vector.
//   word_align() clears the two byte-offset bits of an address.
package fetch_pkg;

    localparam int ADDR_W = 32;
    localparam logic [ADDR_W-1:0] INSTR_STEP           = 32'd4;
    localparam logic [ADDR_W-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        REQ
    } fetch_state_t;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/pc_register.sv
// pc_register
//   Architectural register with synchronous reset-to-vector and load enable.
//   Ports:
//     clock  - clock, rising edge
//     reset  - synchronous active-high reset, loads RESET_VALUE
//     load   - capture d on the next edge
//     d      - next value
//     q      - current value
module pc_register
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_VALUE = DEFAULT_RESET_VECTOR
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] d,
    output logic [ADDR_W-1:0] q
);

    always_ff @(posedge clock) begin
        if (reset) begin
            q <= RESET_VALUE;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Owns the program counter, runs a single-outstanding req/ack transaction
//   with instruction memory and presents fetched words to decode through a
//   stallable one-entry output register.
//   Ports:
//     clock, reset              - clock; synchronous active-high reset
//     branch_valid/target       - redirect pulse from execute and its target
//     stall                     - decode cannot accept the presented instruction
//     imem_req/addr             - fetch request (Mealy) and word-aligned address
//     imem_ack/rdata            - completion strobe and instruction word
//     instr_valid/instr/instr_pc- output register towards decode
//     pc                        - next address to be fetched
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | first cycle after reset, no request
//   ISSUE | may issue a fetch of pc when the output slot is free
//   REQ   | request outstanding, holding req_addr until imem_ack
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              branch_valid,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              stall,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [ADDR_W-1:0] imem_rdata,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [ADDR_W-1:0] pc
);

    fetch_state_t      state;
    logic              discard;
    logic [ADDR_W-1:0] req_addr;

    logic              slot_free;
    logic              consume;
    logic              issue;
    logic              complete;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_next;

    assign slot_free = !instr_valid || !stall;
    assign consume   = instr_valid && !stall;
    // A redirect suppresses a new issue so the fetch starts from the new pc
    assign issue     = (state == ISSUE) && slot_free && !branch_valid;
    assign imem_req  = (state == REQ) || issue;
    assign imem_addr = (state == REQ) ? req_addr : pc;
    assign complete  = imem_req && imem_ack;

    always_comb begin
        pc_load = 1'b0;
        pc_next = pc;
        if (branch_valid) begin
            pc_load = 1'b1;
            pc_next = word_align(branch_target);
        end else if (complete && !discard) begin
            pc_load = 1'b1;
            pc_next = pc + INSTR_STEP;
        end
    end

    pc_register #(
        .RESET_VALUE(RESET_VECTOR)
    ) u_pc (
        .clock(clock),
        .reset(reset),
        .load (pc_load),
        .d    (pc_next),
        .q    (pc)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            discard     <= 1'b0;
            req_addr    <= '0;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
        end else begin
            case (state)
                IDLE: state <= ISSUE;
                ISSUE: begin
                    if (issue) begin
                        req_addr <= pc;
                        state    <= imem_ack ? ISSUE : REQ;
                    end
                end
                REQ: begin
                    if (imem_ack) begin
                        state <= ISSUE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (branch_valid) begin
                instr_valid <= 1'b0;
                // Data returning for the old path must not reach decode
                if (complete) begin
                    discard <= 1'b0;
                end else if (state == REQ) begin
                    discard <= 1'b1;
                end
            end else if (complete && !discard) begin
                instr       <= imem_rdata;
                instr_pc    <= imem_addr;
                instr_valid <= 1'b1;
            end else begin
                if (complete) begin
                    discard <= 1'b0;
                end
                if (consume) begin
                    instr_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        branch_valid;
    logic [31:0] branch_target;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] pc;

    logic        hi_req;
    logic [31:0] hi_addr;
    logic        hi_ack;
    logic [31:0] hi_rdata;
    logic        hi_instr_valid;
    logic [31:0] hi_instr;
    logic [31:0] hi_instr_pc;
    logic [31:0] hi_pc;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          lat      = 0;
    int          cnt;
    int          comp_c   = 0;
    int          comp_t[$];
    logic [31:0] exp_q[$];
    logic [31:0] hi_q[$];
    logic        pend = 1'b0;
    logic [31:0] pend_addr = '0;
    logic [31:0] mon_e;

    always #5 clock = ~clock;

    fetch_sequencer dut (
        .clock        (clock),
        .reset        (reset),
        .branch_valid (branch_valid),
        .branch_target(branch_target),
        .stall        (stall),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .pc           (pc)
    );

    fetch_sequencer #(
        .RESET_VECTOR(32'hFFFF_FFF8)
    ) dut_hi (
        .clock        (clock),
        .reset        (reset),
        .branch_valid (branch_valid),
        .branch_target(branch_target),
        .stall        (stall),
        .imem_req     (hi_req),
        .imem_addr    (hi_addr),
        .imem_ack     (hi_ack),
        .imem_rdata   (hi_rdata),
        .instr_valid  (hi_instr_valid),
        .instr        (hi_instr),
        .instr_pc     (hi_instr_pc),
        .pc           (hi_pc)
    );

    // Memory model: ack after lat waiting cycles, data = addr ^ E000_0000
    assign imem_ack   = imem_req && (cnt == lat);
    assign imem_rdata = imem_addr ^ 32'hE000_0000;
    assign hi_ack     = hi_req;
    assign hi_rdata   = hi_addr ^ 32'hE000_0000;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (reset) cnt <= 0;
        else if (imem_req && !imem_ack) cnt <= cnt + 1;
        else cnt <= 0;
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endfunction

    // Monitor / scoreboard
    always @(negedge clock) begin
        if (reset) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                chk("req_held", {31'd0, imem_req}, 32'd1);
                chk("addr_stable", imem_addr, pend_addr);
            end
            pend      = imem_req && !imem_ack;
            pend_addr = imem_addr;
            if (imem_req && imem_ack) begin
                comp_t.push_back(cyc);
                if (imem_addr == 32'hC) comp_c++;
            end
            if (instr_valid && !stall && !branch_valid && exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("instr_pc", instr_pc, mon_e);
                chk("instr", instr, mon_e ^ 32'hE000_0000);
            end
            if (hi_req && hi_ack && hi_q.size() > 0) begin
                mon_e = hi_q.pop_front();
                chk("hi_addr", hi_addr, mon_e);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        branch_valid = 1'b0;
        stall        = 1'b0;
        repeat (2) step();
        reset = 1'b0;
    endtask

    task automatic wait_empty(input int lim, input string nm);
        for (int i = 0; i < lim && exp_q.size() != 0; i++) step();
        chk({nm, "_drained"}, exp_q.size(), 32'd0);
    endtask

    task automatic wait_req(input logic [31:0] a, input int lim, input string nm);
        for (int i = 0; i < lim && !(imem_req && imem_addr == a); i++) step();
        chk({nm, "_req_seen"}, {31'd0, imem_req && imem_addr == a}, 32'd1);
    endtask

    initial begin
        int c0;
        int b;
        reset         = 1'b1;
        branch_valid  = 1'b0;
        branch_target = '0;
        stall         = 1'b0;

        // Phase A: zero-wait, then stall hold and release
        lat = 0;
        hi_q.push_back(32'hFFFF_FFF8);
        hi_q.push_back(32'hFFFF_FFFC);
        hi_q.push_back(32'h0000_0000);
        hi_q.push_back(32'h0000_0004);
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(4 * i));
        c0 = comp_c;
        do_reset();
        #1;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_hi_pc", hi_pc, 32'hFFFF_FFF8);
        chk("rst_hi_valid", {31'd0, hi_instr_valid}, 32'd0);
        chk("rst_hi_instr", hi_instr ^ hi_instr_pc, 32'd0);
        step();
        chk("c2_req", {31'd0, imem_req}, 32'd1);
        chk("c2_addr", imem_addr, 32'h0);
        chk("c2_valid", {31'd0, instr_valid}, 32'd0);
        step();
        chk("c3_valid", {31'd0, instr_valid}, 32'd1);
        chk("c3_instr_pc", instr_pc, 32'h0);
        chk("c3_addr", imem_addr, 32'h4);
        step();
        chk("c4_instr_pc", instr_pc, 32'h4);
        step();
        chk("c5_instr_pc", instr_pc, 32'h8);
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_hold_pc", instr_pc, 32'h8);
            chk("stall_hold_instr", instr, 32'hE000_0008);
            chk("stall_no_req", {31'd0, imem_req}, 32'd0);
            step();
        end
        stall = 1'b0;
        #1;
        chk("release_req", {31'd0, imem_req}, 32'd1);
        chk("release_addr", imem_addr, 32'hC);
        wait_empty(40, "phaseA");
        chk("one_fetch_of_c", 32'(comp_c - c0), 32'd1);

        // Phase B: ack latency 2 -> one instruction per 3 cycles
        lat = 2;
        do_reset();
        exp_q.delete();
        b = comp_t.size();
        for (int i = 0; i < 4; i++) exp_q.push_back(32'(4 * i));
        wait_empty(60, "phaseB");
        chk("lat2_count", {31'd0, (comp_t.size() - b) >= 3}, 32'd1);
        if (comp_t.size() - b >= 3) begin
            chk("lat2_gap1", 32'(comp_t[b+1] - comp_t[b]), 32'd3);
            chk("lat2_gap2", 32'(comp_t[b+2] - comp_t[b+1]), 32'd3);
        end

        // Phase C: branch while fetch of 0x10 is outstanding
        lat = 2;
        do_reset();
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(32'(4 * i));
        exp_q.push_back(32'h1000);
        exp_q.push_back(32'h1004);
        wait_req(32'h10, 60, "fetch10");
        step();
        branch_valid  = 1'b1;
        branch_target = 32'h0000_1002;
        #1;
        chk("br_outstanding", {31'd0, imem_req && !imem_ack}, 32'd1);
        step();
        branch_valid = 1'b0;
        #1;
        chk("br_valid_drop", {31'd0, instr_valid}, 32'd0);
        chk("br_pc", pc, 32'h1000);
        chk("br_old_addr", imem_addr, 32'h10);
        step();
        chk("br_new_req", {31'd0, imem_req}, 32'd1);
        chk("br_new_addr", imem_addr, 32'h1000);
        wait_empty(40, "phaseC");

        // Phase D: reset while a request waits for ack
        lat = 2;
        do_reset();
        exp_q.delete();
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        wait_req(32'h8, 60, "fetch8");
        step();
        reset = 1'b1;
        #1;
        chk("pre_rst_req", {31'd0, imem_req && !imem_ack}, 32'd1);
        step();
        reset = 1'b0;
        #1;
        chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
        chk("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("mid_rst_pc", pc, 32'h0);
        chk("pre_rst_drained", exp_q.size(), 32'd0);
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(32'(4 * i));
        wait_empty(60, "phaseD");

        chk("hi_seq_drained", hi_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

endmodule
